// File: rtl/battle_round_ctrl.sv
// Round sequencer for the factorization battle: question request, answer window, damage, game over.
// Optional build macro DRAW_DAMAGE_EN: a draw damages both players.
module battle_round_ctrl #(
  parameter int HP_INIT    = 5,
  parameter int HPW        = 4,
  parameter int DMG        = 1,
  parameter int TIME_LIMIT = 1000,
  parameter int GAP_CYC    = 16,
  parameter int TW         = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic           Q_ACK,
  input  logic [1:0]     WL_IN,
  output logic           Q_REQ,
  output logic           JUDGE_EN,
  output logic [HPW-1:0] MY_HP,
  output logic [HPW-1:0] EN_HP,
  output logic [7:0]     ROUND,
  output logic [1:0]     ROUND_RES,
  output logic           GAME_OVER,
  output logic [1:0]     WINNER,
  output logic [2:0]     STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT_Q  = 3'd2,
    S_ANSWER  = 3'd3,
    S_RESOLVE = 3'd4,
    S_GAP     = 3'd5,
    S_OVER    = 3'd6
  } state_e;

  localparam logic [HPW-1:0] HP_RST = HPW'(HP_INIT);
  localparam logic [HPW-1:0] DMG_V  = HPW'(DMG);
  localparam logic [TW-1:0]  T_LAST = TW'(TIME_LIMIT - 1);
  localparam logic [TW-1:0]  G_LAST = (GAP_CYC == 0) ? '0 : TW'(GAP_CYC - 1);
`ifdef DRAW_DAMAGE_EN
  localparam bit DRAW_DMG = 1'b1;
`else
  localparam bit DRAW_DMG = 1'b0;
`endif

  state_e         state_q, state_d;
  logic [HPW-1:0] my_hp_q, my_hp_d, en_hp_q, en_hp_d;
  logic [HPW-1:0] my_post, en_post;
  logic [7:0]     round_q, round_d;
  logic [1:0]     res_q, res_d;
  logic [1:0]     winner_q, winner_d;
  logic [TW-1:0]  timer_q, timer_d;

  function automatic logic [HPW-1:0] sat_sub(input logic [HPW-1:0] hp);
    return (hp > DMG_V) ? (hp - DMG_V) : '0;
  endfunction

  // Handshake: Q_REQ is a one-cycle request pulse; Q_ACK is level-sampled only in
  // WAIT_Q and may arrive any number of cycles later. WL_IN is sampled only while
  // JUDGE_EN is high; a nonzero code on any such cycle closes the window.
  always_comb begin
    state_d  = state_q;
    my_hp_d  = my_hp_q;
    en_hp_d  = en_hp_q;
    round_d  = round_q;
    res_d    = res_q;
    winner_d = winner_q;
    timer_d  = timer_q;

    // Post-damage HP, evaluated from the latched round result.
    my_post = my_hp_q;
    en_post = en_hp_q;
    if (res_q == 2'b01 || (DRAW_DMG && res_q == 2'b11)) en_post = sat_sub(en_hp_q);
    if (res_q == 2'b10 || (DRAW_DMG && res_q == 2'b11)) my_post = sat_sub(my_hp_q);

    case (state_q)
      S_IDLE, S_OVER: begin
        if (START) begin
          my_hp_d  = HP_RST;
          en_hp_d  = HP_RST;
          round_d  = '0;
          res_d    = 2'b00;
          winner_d = 2'b00;
          state_d  = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT_Q;
      S_WAIT_Q: begin
        if (Q_ACK) begin
          timer_d = '0;
          state_d = S_ANSWER;
        end
      end
      S_ANSWER: begin
        timer_d = timer_q + TW'(1);
        // An answer on the final window cycle takes priority over the timeout.
        if (WL_IN != 2'b00) begin
          res_d   = WL_IN;
          state_d = S_RESOLVE;
        end else if (timer_q >= T_LAST) begin
          res_d   = 2'b00;
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        my_hp_d = my_post;
        en_hp_d = en_post;
        round_d = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
        if (my_post == '0 && en_post == '0) begin
          winner_d = 2'b11;
          state_d  = S_OVER;
        end else if (en_post == '0) begin
          winner_d = 2'b01;
          state_d  = S_OVER;
        end else if (my_post == '0) begin
          winner_d = 2'b10;
          state_d  = S_OVER;
        end else begin
          timer_d = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q >= G_LAST) state_d = S_REQ;
        else timer_d = timer_q + TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      my_hp_q  <= HP_RST;
      en_hp_q  <= HP_RST;
      round_q  <= '0;
      res_q    <= 2'b00;
      winner_q <= 2'b00;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      my_hp_q  <= my_hp_d;
      en_hp_q  <= en_hp_d;
      round_q  <= round_d;
      res_q    <= res_d;
      winner_q <= winner_d;
      timer_q  <= timer_d;
    end
  end

  assign Q_REQ     = (state_q == S_REQ);
  assign JUDGE_EN  = (state_q == S_ANSWER);
  assign GAME_OVER = (state_q == S_OVER);
  assign MY_HP     = my_hp_q;
  assign EN_HP     = en_hp_q;
  assign ROUND     = round_q;
  assign ROUND_RES = res_q;
  assign WINNER    = winner_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_battle_round_ctrl.sv
// Bench for battle_round_ctrl: driver tasks, round-result scoreboard, direct checks, summary.
module tb_battle_round_ctrl;

  localparam int HP_INIT    = 5;
  localparam int HPW        = 4;
  localparam int DMG        = 1;
  localparam int TIME_LIMIT = 1000;
  localparam int GAP_CYC    = 16;
  localparam int TW         = 16;
  localparam int SB_W       = 1 + 2 + 2 + 8 + 2 * HPW;

  logic           CLK = 1'b0;
  logic           RST;
  logic           START;
  logic           Q_ACK;
  logic [1:0]     WL_IN;
  logic           Q_REQ;
  logic           JUDGE_EN;
  logic [HPW-1:0] MY_HP;
  logic [HPW-1:0] EN_HP;
  logic [7:0]     ROUND;
  logic [1:0]     ROUND_RES;
  logic           GAME_OVER;
  logic [1:0]     WINNER;
  logic [2:0]     STATE;

  battle_round_ctrl #(
    .HP_INIT(HP_INIT), .HPW(HPW), .DMG(DMG),
    .TIME_LIMIT(TIME_LIMIT), .GAP_CYC(GAP_CYC), .TW(TW)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .Q_ACK(Q_ACK), .WL_IN(WL_IN),
    .Q_REQ(Q_REQ), .JUDGE_EN(JUDGE_EN), .MY_HP(MY_HP), .EN_HP(EN_HP),
    .ROUND(ROUND), .ROUND_RES(ROUND_RES), .GAME_OVER(GAME_OVER),
    .WINNER(WINNER), .STATE(STATE)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // check + counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  // reference model + scoreboard
  logic [SB_W-1:0] exp_q[$];
  logic [HPW-1:0]  m_my, m_en;
  logic [7:0]      m_round;
  logic [1:0]      m_res, m_win;

  function automatic logic [HPW-1:0] m_sub(input logic [HPW-1:0] hp);
    return (int'(hp) > DMG) ? HPW'(int'(hp) - DMG) : '0;
  endfunction

  task automatic model_start();
    m_my = HPW'(HP_INIT); m_en = HPW'(HP_INIT);
    m_round = 8'd0; m_res = 2'b00; m_win = 2'b00;
  endtask

  task automatic model_round(input logic [1:0] res);
    if (res == 2'b01) m_en = m_sub(m_en);
    if (res == 2'b10) m_my = m_sub(m_my);
`ifdef DRAW_DAMAGE_EN
    if (res == 2'b11) begin m_en = m_sub(m_en); m_my = m_sub(m_my); end
`endif
    if (m_round != 8'd255) m_round = m_round + 8'd1;
    m_res = res;
    if (m_my == '0 && m_en == '0) m_win = 2'b11;
    else if (m_en == '0)          m_win = 2'b01;
    else if (m_my == '0)          m_win = 2'b10;
    exp_q.push_back({(m_win != 2'b00), m_win, m_res, m_round, m_my, m_en});
  endtask

  // Compares the architectural outputs on the cycle after each RESOLVE.
  initial begin
    bit seen_resolve = 1'b0;
    logic [SB_W-1:0] e;
    forever begin
      @(negedge CLK);
      if (seen_resolve) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("sb_round", {GAME_OVER, WINNER, ROUND_RES, ROUND, MY_HP, EN_HP}, e);
        end
      end
      seen_resolve = (STATE == 3'd4) && !RST;
    end
  end

  // drivers
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic start_game();
    START = 1'b1;
    model_start();
    tick();
    START = 1'b0;
  endtask

  // Waits for the Q_REQ pulse; cnt = cycles waited. poke pulses START on the first waited cycle.
  task automatic wait_qreq(input bit poke, output int cnt);
    cnt = 0;
    while (!Q_REQ && cnt < 5000) begin
      tick();
      cnt++;
      START = poke && (cnt == 1);
    end
    START = 1'b0;
    check("qreq_seen", Q_REQ, 1);
  endtask

  // Entered on a cycle where Q_REQ is high. wl is driven on ANSWER cycle 'delay' (0-based).
  task automatic play_round(input logic [1:0] wl, input int delay, input int ack_gap,
                            input bit poke, output int ans);
    model_round(wl);
    tick();
    check("qreq_pulse_len", Q_REQ, 0);
    START = poke;
    repeat (ack_gap - 1) begin
      tick();
      START = 1'b0;
    end
    check("wait_q_state", STATE, 3'd2);
    Q_ACK = 1'b1;
    tick();
    Q_ACK = 1'b0;
    START = 1'b0;
    check("judge_en", JUDGE_EN, 1);
    ans = 0;
    for (int c = 0; c < TIME_LIMIT + 5; c++) begin
      if (STATE != 3'd3) break;
      ans++;
      WL_IN = (c == delay) ? wl : 2'b00;
      tick();
    end
    WL_IN = 2'b00;
    check("resolve_state", STATE, 3'd4);
  endtask

  task automatic post_round();
    tick();
    check("post_state", STATE, (m_win != 2'b00) ? 3'd6 : 3'd5);
  endtask

  task automatic do_round(input logic [1:0] wl, input int delay, input bit poke_wait,
                          output int ans, output int gap);
    wait_qreq(1'b0, gap);
    play_round(wl, delay, poke_wait ? 2 : $urandom_range(1, 4), poke_wait, ans);
    post_round();
  endtask

  // main sequence
  initial begin
    int ans, gap;
    RST = 1'b1; START = 1'b0; Q_ACK = 1'b0; WL_IN = 2'b00;
    model_start();
    repeat (3) tick();
    check("rst_state", STATE, 3'd0);
    check("rst_my_hp", MY_HP, HP_INIT);
    check("rst_en_hp", EN_HP, HP_INIT);
    check("rst_round", ROUND, 0);
    check("rst_res", ROUND_RES, 0);
    check("rst_winner", WINNER, 0);
    check("rst_outs", {Q_REQ, JUDGE_EN, GAME_OVER}, 0);
    RST = 1'b0;
    repeat (2) tick();
    check("idle_hold", STATE, 3'd0);

    // First round: mine wins on the first ANSWER cycle, START poked in WAIT_Q.
    start_game();
    check("start_req", STATE, 3'd1);
    do_round(2'b01, 0, 1'b1, ans, gap);
    check("first_ans_len", ans, 1);

    // GAP length, with START poked during GAP; then a full timeout window.
    wait_qreq(1'b1, gap);
    check("gap_len", gap, GAP_CYC);
    play_round(2'b00, 0, $urandom_range(1, 4), 1'b0, ans);
    post_round();
    check("timeout_len", ans, TIME_LIMIT);

    // Answer on the final window cycle beats the timeout.
    do_round(2'b01, TIME_LIMIT - 1, 1'b0, ans, gap);
    check("late_ans_len", ans, TIME_LIMIT);

    // Enemy wins five rounds: game over.
    for (int i = 0; i < 5; i++) do_round(2'b10, $urandom_range(0, 3), 1'b0, ans, gap);
    WL_IN = 2'b01; Q_ACK = 1'b1;
    repeat (5) tick();
    WL_IN = 2'b00; Q_ACK = 1'b0;
    check("over_state", STATE, 3'd6);
    check("over_flag", GAME_OVER, 1);
    check("over_winner", WINNER, 2'b10);
    check("over_my_hp", MY_HP, 0);
    check("over_en_hold", EN_HP, m_en);
    check("over_no_req", Q_REQ, 0);

    // Restart from OVER.
    start_game();
    check("restart_state", STATE, 3'd1);
    check("restart_qreq", Q_REQ, 1);
    check("restart_my_hp", MY_HP, HP_INIT);
    check("restart_en_hp", EN_HP, HP_INIT);
    check("restart_round", ROUND, 0);
    check("restart_winner", WINNER, 0);

    // Bring both HP to 1, then a draw.
    for (int i = 0; i < 2 * (HP_INIT - 1); i++)
      do_round((i % 2 == 0) ? 2'b01 : 2'b10, $urandom_range(0, 5), 1'b0, ans, gap);
    check("pre_draw_my", MY_HP, 1);
    check("pre_draw_en", EN_HP, 1);
    do_round(2'b11, $urandom_range(0, 5), 1'b0, ans, gap);

    // Reset while in ANSWER with MY_HP = 2; pending WL_IN/Q_ACK must be ignored.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    start_game();
    for (int i = 0; i < HP_INIT - 2; i++) do_round(2'b10, 0, 1'b0, ans, gap);
    wait_qreq(1'b0, gap);
    tick();
    Q_ACK = 1'b1;
    tick();
    check("pre_rst_answer", STATE, 3'd3);
    check("pre_rst_my_hp", MY_HP, 2);
    RST = 1'b1; WL_IN = 2'b01;
    tick();
    model_start();
    check("midrst_state", STATE, 3'd0);
    check("midrst_my_hp", MY_HP, HP_INIT);
    check("midrst_en_hp", EN_HP, HP_INIT);
    check("midrst_judge_en", JUDGE_EN, 0);
    check("midrst_round", ROUND, 0);
    check("midrst_res", ROUND_RES, 0);
    RST = 1'b0;
    repeat (3) tick();
    WL_IN = 2'b00; Q_ACK = 1'b0;
    check("post_rst_idle", STATE, 3'd0);
    check("post_rst_no_req", Q_REQ, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
